axil_slave_regfile: RTL
=======================

AXIL_SLAVE_REGFILE -- requirements
Module: axil_slave_regfile

Interface
REQ-001 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width giving 8 word registers.
REQ-003 The block SHALL have parameter C_ID_VALUE, default 32'hA5A5_0001, constant read from register 7.
REQ-004 Port ACLK, input, 1: the single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 Port ARESETN, input, 1: reset, synchronous and active-low.
REQ-006 Write address ports SHALL be S_AXI_AWADDR in [ADDR_WIDTH], S_AXI_AWPROT in [3] (ignored), S_AXI_AWVALID in [1] and S_AXI_AWREADY out [1].
REQ-007 Write data ports SHALL be S_AXI_WDATA in [32], S_AXI_WSTRB in [4], S_AXI_WVALID in [1] and S_AXI_WREADY out [1].
REQ-008 Write response ports SHALL be S_AXI_BRESP out [2], S_AXI_BVALID out [1] and S_AXI_BREADY in [1].
REQ-009 Read address ports SHALL be S_AXI_ARADDR in [ADDR_WIDTH], S_AXI_ARPROT in [3] (ignored), S_AXI_ARVALID in [1] and S_AXI_ARREADY out [1].
REQ-010 Read data ports SHALL be S_AXI_RDATA out [32], S_AXI_RRESP out [2], S_AXI_RVALID out [1] and S_AXI_RREADY in [1].

Function
REQ-011 The register index SHALL be addr[4:2]; addr[1:0] SHALL be ignored.
REQ-012 Registers 0-6 SHALL be read/write; register 7 SHALL be read-only and return C_ID_VALUE.
REQ-013 AW and W SHALL be accepted independently: AWREADY=1 while no address is held, WREADY=1 while no data is held; each handshake latches its payload and drops its READY.
REQ-014 In the cycle after both address and data are held and BVALID=0, the write SHALL commit per WSTRB byte lane, BVALID SHALL rise, and both holding flags SHALL clear.
REQ-015 Latency: AW and W handshaking in cycle N SHALL give the register update and BVALID=1 in cycle N+1.
REQ-016 BRESP SHALL be OKAY (2'b00) for registers 0-6; a write to register 7 SHALL return SLVERR (2'b10) and change no state.
REQ-017 BVALID SHALL hold with a stable BRESP until the BVALID&BREADY handshake; no new AW or W SHALL be accepted while BVALID=1.
REQ-018 The read FSM SHALL have two states: IDLE (ARREADY=1) and RESP (ARREADY=0, RVALID=1).
REQ-019 An AR handshake in IDLE in cycle N SHALL capture the register contents and give RVALID=1, RRESP=OKAY in cycle N+1.
REQ-020 In RESP, RDATA and RRESP SHALL remain stable until RVALID&RREADY, then the FSM SHALL return to IDLE with ARREADY=1 next cycle.
REQ-021 If a read captures data in the same cycle a write commits to the same register, the read SHALL return the pre-write value.
REQ-022 The read and write channels SHALL operate concurrently without stalling each other.
REQ-023 WSTRB=4'b0000 SHALL complete with OKAY and change no data.

Reset
REQ-024 While ARESETN=0 at a rising ACLK, registers 0-6 SHALL clear to 0; AWREADY, WREADY, BVALID and RVALID SHALL be 0; BRESP, RRESP and RDATA SHALL be 0; the read FSM SHALL be in IDLE and the holding flags SHALL clear.
REQ-025 A reset mid-transaction SHALL discard held address, data and response; the first cycle after release SHALL show AWREADY=WREADY=ARREADY=1.

Structure
REQ-026 A shared package SHALL hold the RESP_OKAY/RESP_SLVERR constants, the register count (8), the ID register index (7) and the read-FSM state encoding.
REQ-027 One sub-module, axil_regfile_core, SHALL implement the 7x32 strobed storage with one write port and one combinational read port; the AXI channel logic SHALL stay in the top module.

Verification
REQ-028 Reset, then write 0x1234_5678 to 0x04 with WSTRB=4'hF, AW and W in the same cycle -> BVALID next cycle, BRESP=00; reading 0x04 -> 0x1234_5678, RRESP=00.
REQ-029 W three cycles before AW, data 0xFFFF_FFFF, WSTRB=4'b0101 to 0x08 (previously 0) -> WREADY low until the write commits; read returns 0x00FF_00FF.
REQ-030 Write 0xDEAD_BEEF to 0x1C -> BRESP=10; reading 0x1C returns 0xA5A5_0001.
REQ-031 Hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID, RVALID, RDATA and BRESP stay stable; AWREADY, WREADY and ARREADY stay 0.
REQ-032 Assert ARESETN=0 for one cycle while BVALID=1 -> BVALID=0 and register 1 reads 0 after release.
REQ-033 Same-cycle AR and write commit to 0x0C (old value 0x11, new value 0x22) -> first read returns 0x11, second read returns 0x22.

Source files
------------

// File: rtl/axil_slave_regfile_pkg.sv
// axil_slave_regfile_pkg: shared response codes, register map constants and read-FSM encoding
package axil_slave_regfile_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int NUM_REGS = 8;
  localparam logic [2:0] ID_IDX = 3'd7;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
endpackage

// File: rtl/axil_regfile_core.sv
// axil_regfile_core: seven 32-bit registers with one byte-strobed write port and one combinational read port
module axil_regfile_core
  import axil_slave_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [2:0]  raddr,
  output logic [31:0] rdata
);
  logic [31:0] mem [NUM_REGS-1];
  // byte-lane writes into the addressed register; the ID slot has no storage
  always_ff @(posedge clk)
    for (int r = 0; r < NUM_REGS-1; r++)
      if (!resetn) mem[r] <= '0;
      else if (we && waddr == 3'(r))
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) mem[r][8*b +: 8] <= wdata[8*b +: 8];
  // combinational read; the ID slot reads as zero here and is substituted by the caller
  always_comb begin
    rdata = '0;
    for (int r = 0; r < NUM_REGS-1; r++)
      if (raddr == 3'(r)) rdata = mem[r];
  end
endmodule

// File: rtl/axil_slave_regfile.sv
// axil_slave_regfile: AXI4-Lite slave with seven read/write registers and a read-only ID register
module axil_slave_regfile
  import axil_slave_regfile_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 5,
  parameter logic [31:0] C_ID_VALUE         = 32'hA5A5_0001
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);
  logic        aw_held, w_held, aw_hs, w_hs, ar_hs, commit, unused;
  logic [2:0]  aw_idx, wr_idx;
  logic [31:0] w_data, wr_data, core_rdata;
  logic [3:0]  w_strb, wr_strb;
  rd_state_t   rd_state, rd_next;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign S_AXI_AWREADY = ARESETN && !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY = ARESETN && !w_held && !S_AXI_BVALID;
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs = S_AXI_WVALID && S_AXI_WREADY;
  assign commit = (aw_held || aw_hs) && (w_held || w_hs) && !S_AXI_BVALID;
  assign wr_idx = aw_held ? aw_idx : S_AXI_AWADDR[4:2];
  assign wr_data = w_held ? w_data : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb : S_AXI_WSTRB;
  axil_regfile_core u_core (
    .clk    (ACLK),
    .resetn (ARESETN),
    .we     (commit && wr_idx != ID_IDX),
    .waddr  (wr_idx),
    .wdata  (wr_data),
    .wstrb  (wr_strb),
    .raddr  (S_AXI_ARADDR[4:2]),
    .rdata  (core_rdata)
  );
  // hold AW/W payloads independently; commit as soon as both are present, bypassing the holding registers
  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= RESP_OKAY;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      S_AXI_BVALID <= 1'b1;
      S_AXI_BRESP <= wr_idx == ID_IDX ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx <= S_AXI_AWADDR[4:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
    end
  // read FSM state and captured read data; capture sees pre-write contents
  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      rd_state <= RD_IDLE;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs) begin
        S_AXI_RDATA <= S_AXI_ARADDR[4:2] == ID_IDX ? C_ID_VALUE : core_rdata;
        S_AXI_RRESP <= RESP_OKAY;
      end
    end
  // read next-state and handshake outputs
  always_comb begin
    S_AXI_ARREADY = ARESETN && rd_state == RD_IDLE;
    S_AXI_RVALID = rd_state == RD_RESP;
    ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    rd_next = rd_state == RD_IDLE ? (ar_hs ? RD_RESP : RD_IDLE) : (S_AXI_RREADY ? RD_IDLE : RD_RESP);
  end
endmodule
